// File: rtl/ebike_pkg.sv
// Shared types and constants for the e-bike motor drive datapath.
package ebike_pkg;
    localparam int DUTY_W     = 11;
    localparam int PWM_PERIOD = 2048;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } slew_state_t;
endpackage

// File: rtl/duty_slew_if.sv
// Control/status bundle between the motor controller and the duty slew limiter.
interface duty_slew_if;
    import ebike_pkg::*;

    logic              en;
    logic [DUTY_W-1:0] target;
    logic [3:0]        step;
    logic              fault;
    logic              clr_fault;
    logic [DUTY_W-1:0] duty;
    logic              at_target;
    logic              fault_latched;
    logic              period_start;

    modport master (
        output en, target, step, fault, clr_fault,
        input  duty, at_target, fault_latched, period_start
    );

    modport slave (
        input  en, target, step, fault, clr_fault,
        output duty, at_target, fault_latched, period_start
    );
endinterface

// File: rtl/duty_period_tmr.sv
// PWM period counter plus update-tick divider, phase-locked to the PWM stage.
module duty_period_tmr
    import ebike_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_period_start,
    output logic o_tick
);
    localparam logic [DUTY_W-1:0] PCNT_MAX = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [3:0]        DIV_MAX  = 4'(TICK_DIV - 1);

    logic              r_run;
    logic [DUTY_W-1:0] r_pcnt;
    logic [3:0]        r_div;
    logic              r_pstart;
    logic              w_wrap;

    assign w_wrap = (r_pcnt == PCNT_MAX);

    // First edge after reset holds the count at 0 and marks the first period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_pcnt   <= '0;
            r_div    <= '0;
            r_pstart <= 1'b0;
        end else begin
            r_run    <= 1'b1;
            r_pstart <= !r_run || w_wrap;
            if (r_run) begin
                r_pcnt <= r_pcnt + 1'b1;
                if (w_wrap)
                    r_div <= (r_div == DIV_MAX) ? 4'd0 : r_div + 4'd1;
            end
        end
    end

    assign o_period_start = r_pstart;
    assign o_tick         = r_run && w_wrap && (r_div == DIV_MAX);
endmodule

// File: rtl/duty_slew.sv
// Slew-rate limiter for the PWM duty command with latched emergency stop.
module duty_slew
    import ebike_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    duty_slew_if.slave  bus
);
    slew_state_t       r_state, w_state_n;
    logic [DUTY_W-1:0] r_duty, w_duty_n;
    logic              r_at, w_at_n;
    logic              r_flt, w_flt_n;

    logic              w_tick;
    logic              w_pstart;
    logic [DUTY_W-1:0] w_eff;
    logic signed [11:0] w_diff;
    logic [11:0]       w_mag;
    logic [11:0]       w_step12;
    logic              w_close;
    logic [DUTY_W-1:0] w_slew;
    logic              w_reach;

    duty_period_tmr #(.TICK_DIV(TICK_DIV)) u_tmr (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_period_start (w_pstart),
        .o_tick         (w_tick)
    );

    assign w_eff    = bus.en ? bus.target : '0;
    assign w_diff   = $signed({1'b0, w_eff}) - $signed({1'b0, r_duty});
    assign w_mag    = w_diff[11] ? (~w_diff + 12'sd1) : w_diff;
    assign w_step12 = {8'd0, bus.step};
    assign w_close  = (w_mag <= w_step12);
    assign w_reach  = w_close && (bus.step != 4'd0);

    // A larger gap than one step can never overshoot, so no clamping needed.
    always_comb begin
        w_slew = r_duty;
        if (w_close)
            w_slew = w_eff;
        else if (!w_diff[11])
            w_slew = r_duty + {7'd0, bus.step};
        else
            w_slew = r_duty - {7'd0, bus.step};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_duty  <= '0;
            r_at    <= 1'b0;
            r_flt   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_duty  <= w_duty_n;
            r_at    <= w_at_n;
            r_flt   <= w_flt_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        if (bus.fault) begin
            w_state_n = S_FAULT;
        end else begin
            unique case (r_state)
                S_IDLE:
                    if (w_eff != '0) w_state_n = S_RAMP;
                S_RAMP:
                    if (w_tick && w_reach)
                        w_state_n = (w_eff == '0) ? S_IDLE : S_HOLD;
                S_HOLD:
                    if (w_eff != r_duty) w_state_n = S_RAMP;
                S_FAULT:
                    if (bus.clr_fault) w_state_n = S_IDLE;
                default:
                    w_state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_duty_n = r_duty;
        if (bus.fault)
            w_duty_n = '0;
        else if (r_state == S_RAMP && w_tick)
            w_duty_n = w_slew;
        w_at_n  = (w_state_n == S_HOLD) && (w_duty_n == w_eff);
        w_flt_n = (w_state_n == S_FAULT);
    end

    assign bus.duty          = r_duty;
    assign bus.at_target     = r_at;
    assign bus.fault_latched = r_flt;
    assign bus.period_start  = w_pstart;
endmodule

// File: doc/duty_slew.md
DUTY_SLEW -- requirements
Module: duty_slew

Interface
REQ-001 Parameter TICK_DIV, default 4, number of 2048-clock PWM periods between duty updates; legal range 1..16.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  drive enable; 0 = ramp toward zero.
REQ-005 target  input  11  requested duty, unsigned, 0..2047.
REQ-006 step  input  4  maximum duty change per update, unsigned; 0 = freeze.
REQ-007 fault  input  1  level-sensitive emergency stop request.
REQ-008 clr_fault  input  1  single-cycle request to release a latched fault.
REQ-009 duty  output  11  slew-limited duty, registered, drives the downstream PWM stage.
REQ-010 at_target  output  1  registered; 1 when duty equals the effective target and state is HOLD.
REQ-011 fault_latched  output  1  registered; 1 while in FAULT.
REQ-012 period_start  output  1  registered; high for exactly one clock at the start of each 2048-clock period.

Function
REQ-013 An 11-bit period counter SHALL increment every clock and wrap 2047->0, so its phase matches a downstream PWM counter released from the same reset.
REQ-014 period_start SHALL be 1 exactly in the cycles where the period counter equals 0.
REQ-015 A divide counter SHALL advance on each 2047->0 wrap, wrapping at TICK_DIV-1; an update tick SHALL occur on the edge where the period counter is 2047 and the divide counter is TICK_DIV-1.
REQ-016 duty SHALL change only on update-tick edges or on fault entry, so a new value is first visible when the period counter is 0.
REQ-017 Effective target SHALL be target when en=1, else 0.
REQ-018 On a tick: if |eff_target - duty| <= step, duty <= eff_target; otherwise duty moves toward eff_target by step. Arithmetic SHALL be 12-bit signed, with no wrap past 0 or 2047.
REQ-019 States: IDLE, RAMP, HOLD, FAULT.
REQ-020 IDLE (duty=0): go to RAMP when eff_target != 0.
REQ-021 RAMP: go to HOLD on the tick where duty reaches eff_target; go to IDLE instead if that value is 0.
REQ-022 HOLD: go to RAMP when eff_target != duty, evaluated every clock; the next move occurs on the next tick.
REQ-023 Any state: fault=1 forces duty to 0 and the state to FAULT on the next edge, regardless of tick.
REQ-024 FAULT: go to IDLE on an edge where clr_fault=1 and fault=0; if both are 1 in the same cycle, fault wins and FAULT is held.
REQ-025 step=0 in RAMP: duty SHALL hold and the state SHALL remain RAMP; no lock-up, and progress resumes when step becomes nonzero.
REQ-026 Changes to target or en mid-ramp SHALL take effect at the next tick, and direction may reverse.
REQ-027 at_target SHALL be 0 in IDLE, RAMP and FAULT.

Reset
REQ-028 While rst_n=0: duty=0, at_target=0, fault_latched=0, period_start=0, both counters=0, state=IDLE.
REQ-029 Reset asserted mid-ramp or in FAULT SHALL clear everything per REQ-028 with no fault memory.
REQ-030 The first period_start SHALL occur on the first clock edge after rst_n deasserts, when the counter is 0.

Structure
REQ-031 A shared package ebike_pkg SHALL hold the slew_state_t enum, DUTY_W=11 and PWM_PERIOD=2048.
REQ-032 The period and divide counters SHALL form one sub-module, duty_period_tmr, with outputs period_start and tick.

Verification
REQ-033 Ramp up: en=1, target=100, step=10, TICK_DIV=1 -> duty 10,20,...,100 at successive period starts, then HOLD with at_target=1 after the 10th tick.
REQ-034 Final partial step: target=25, step=10 -> duty 10, 20, 25, then HOLD.
REQ-035 Fault: fault=1 mid-ramp at duty=60 -> duty=0 and fault_latched=1 on the next edge; clr_fault and fault both 1 -> FAULT held; fault=0 with clr_fault=1 -> IDLE.
REQ-036 en drop: in HOLD at 2047 with step=15, en=0 -> duty ramps down by 15 per tick, ends at exactly 0, state IDLE.
REQ-037 TICK_DIV=4 -> duty changes only every 8192 clocks, and only at period starts where the counter is 0.
REQ-038 Reset mid-ramp at duty=300 -> all outputs 0 asynchronously; period_start resumes on the first edge after release.
